// File: rtl/nibble_adder_sched.sv
// Two-requester round-robin scheduler sharing one 4-bit adder for WIDTH-bit adds, LS nibble first.
// Optional macro OVERFLOW_FLAG_EN adds the res_ovf signed-overflow output.

module bit_4adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_adder_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             res_ovf
`endif
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             c_q, c_d, id_q, id_d, last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    logic       any_valid, grant1;
    logic [3:0] add_sum;
    logic       add_cout;

    bit_4adder u_adder (
        .a   (a_q[4*cnt_q +: 4]),
        .b   (b_q[4*cnt_q +: 4]),
        .cin (c_q),
        .sum (add_sum),
        .cout(add_cout)
    );

    // On a tie the requester that did not win last time gets the grant.
    assign any_valid = req0_valid | req1_valid;
    assign grant1    = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        c_d        = c_q;
        id_d       = id_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d      = ovf_q;
`endif
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    req0_ready = any_valid && !grant1;
                    req1_ready = any_valid && grant1;
                end
                if (any_valid) begin
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                    c_d     = grant1 ? req1_cin : req0_cin;
                    id_d    = grant1;
                    last_d  = grant1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*cnt_q +: 4] = add_sum;
                c_d                 = add_cout;
                if (cnt_q == CW'(NIB - 1)) begin
                    state_d = DONE;
`ifdef OVERFLOW_FLAG_EN
                    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_sum   = sum_q;
    assign res_cout  = c_q;
    assign res_id    = id_q;
`ifdef OVERFLOW_FLAG_EN
    assign res_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_adder_sched.sv
// Self-checking bench for nibble_adder_sched: directed table, arbitration, backpressure,
// mid-run reset and randomized transactions against an arithmetic reference model.

module tb_nibble_adder_sched;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_cin;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_cin;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             res_valid, res_ready, res_cout, res_id;
    logic [WIDTH-1:0] res_sum;
    logic             ovf_bit;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nibble_adder_sched #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_cin  (req0_cin),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_cin  (req1_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
`ifdef OVERFLOW_FLAG_EN
        ,
        .res_ovf   (ovf_bit)
`endif
    );
`ifndef OVERFLOW_FLAG_EN
    assign ovf_bit = 1'b0;
`endif

    typedef struct {
        int               who;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             eo;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain wide addition and the two's-complement overflow rule.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin);
        logic [WIDTH:0] full;
        logic           ovf;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {ovf, full};
    endfunction

    task automatic run_one(input int who, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input int hold, input logic [WIDTH-1:0] es,
                           input logic ec, input logic eo);
        logic got_ready;
        int   k;
        @(negedge clk);
        if (who == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end
        got_ready = 1'b0;
        for (int t = 0; t < 20 && !got_ready; t++) begin
            #1;
            if ((who == 0) ? req0_ready : req1_ready) got_ready = 1'b1;
            else @(negedge clk);
        end
        check("accept", {31'd0, got_ready}, 32'd1);
        if (!got_ready) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        k = 0;
        while (!res_valid && k < 20) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("latency", k, NIB);
        check("sum", {16'd0, res_sum}, {16'd0, es});
        check("cout", {31'd0, res_cout}, {31'd0, ec});
        check("id", {31'd0, res_id}, who);
`ifdef OVERFLOW_FLAG_EN
        check("ovf", {31'd0, ovf_bit}, {31'd0, eo});
`endif
        if (hold > 0) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
                check("hold_out", {13'd0, res_valid, res_sum, res_cout, res_id, ovf_bit},
                      {13'd0, 1'b1, es, ec, who[0], (`ifdef OVERFLOW_FLAG_EN eo `else 1'b0 `endif)});
                check("hold_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("valid_fall", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        int nres, nrdy, seen;
        logic [WIDTH+1:0] m;
        int who;
        logic [WIDTH-1:0] ra, rb;
        logic rc;

        vecs[0] = '{0, 16'h00FB, 16'h0001, 1'b0, 16'h00FC, 1'b0, 1'b0};
        vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{1, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0};
        vecs[4] = '{0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{0, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h0011; req0_b = 16'h0022; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0033; req1_b = 16'h0044; req1_cin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", {13'd0, res_valid, res_sum, res_cout, res_id, ovf_bit}, 32'd0);
        check("reset_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("first_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        req0_valid = 1'b0; req1_valid = 1'b0;

        for (int i = 0; i < 7; i++)
            run_one(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].cin, (i == 1) ? 5 : 0,
                    vecs[i].es, vecs[i].ec, vecs[i].eo);

        // Arbitration: both requesters hold valid; reset first so req0 wins the first tie.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd1; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd2; req1_b = 16'd2; req1_cin = 1'b0;
        res_ready = 1'b1;
        nres = 0; nrdy = 0;
        for (int c = 0; c < 4 * (NIB + 2); c++) begin
            #1;
            if (req0_ready || req1_ready) nrdy++;
            if (res_valid) begin
                check("arb_id", {31'd0, res_id}, nres % 2);
                check("arb_sum", {16'd0, res_sum}, (nres % 2 == 0) ? 32'd2 : 32'd4);
                check("arb_busy_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
                nres++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        check("arb_results", nres, 4);
        check("arb_grants", nrdy, 4);

        // Mid-run reset at cnt==2: that transaction must never produce a result.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'hAAAA; req0_b = 16'h5555; req0_cin = 1'b1;
        #1;
        check("midrst_accept", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk); req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; res_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < NIB + 3; c++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        res_ready = 1'b0;
        check("midrst_no_result", seen, 0);
        run_one(0, 16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            who = $urandom_range(0, 1);
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rc  = 1'($urandom);
            m   = model(ra, rb, rc);
            run_one(who, ra, rb, rc, $urandom_range(0, 3), m[WIDTH-1:0], m[WIDTH], m[WIDTH+1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
